// File: rtl/cpu_loader_pkg.sv
// ---------------------------------------------------------------------------
// cpu_loader_pkg
// Shared definitions for the host-side CPU memory loader.
//   - op_t     : command opcodes carried in header bits [31:30]
//   - state_t  : loader state machine encoding
//   - header field positions (opcode slice, enable bit)
// ---------------------------------------------------------------------------
package cpu_loader_pkg;

  // Header field positions.
  localparam int HDR_OP_HI  = 31;
  localparam int HDR_OP_LO  = 30;
  localparam int HDR_EN_BIT = 0;

  // Command opcodes.
  typedef enum logic [1:0] {
    OP_IMEM   = 2'b00,
    OP_DMEM   = 2'b01,
    OP_ENABLE = 2'b10,
    OP_DUMP   = 2'b11
  } op_t;

  // Loader states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_BASE = 3'd1,
    ST_IMEM = 3'd2,
    ST_DLO  = 3'd3,
    ST_DHI  = 3'd4,
    ST_RD   = 3'd5,
    ST_WAIT = 3'd6,
    ST_OUT  = 3'd7
  } state_t;

endpackage

// File: rtl/cpu_mem_loader.sv
// ---------------------------------------------------------------------------
// cpu_mem_loader
// Host-side initiator for the CPU's external memory ports. Consumes a 32-bit
// command/payload stream and writes instruction memory, writes/dumps data
// memory, and drives the CPU enable line.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_data  : command/payload word in (in_ready = accepted)
//   out_valid/out_data: 64-bit dump word out (out_ready = taken by host)
//   cpu_enable        : CPU enable line
//   addr_ext, wen_ext, ren_ext, wdata_ext          : instruction memory port
//   addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
//   rdata_ext_2                                     : data memory port
//   busy              : high whenever the loader is not idle
// ---------------------------------------------------------------------------
module cpu_mem_loader
  import cpu_loader_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [63:0] out_data,
  input  logic        out_ready,
  output logic        cpu_enable,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  input  logic [63:0] rdata_ext_2,
  output logic        busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  op_t              r_op;
  logic [CNT_W-1:0] r_cnt;
  logic [63:0]      r_addr;
  logic [31:0]      r_lowBeat;
  logic             r_live;

  logic             w_readyState;
  logic             w_inAccept;
  logic             w_lastWord;
  op_t              w_hdrOp;
  logic [CNT_W-1:0] w_hdrCnt;
  logic [63:0]      w_baseAddr;
  logic [63:0]      w_nextAddr8;

  // The input side is open only in the states that consume stream words.
  // r_live keeps in_ready low through the reset cycle so it rises only the
  // cycle after rst is released.
  assign w_readyState = (r_state == ST_IDLE) || (r_state == ST_BASE) ||
                        (r_state == ST_IMEM) || (r_state == ST_DLO)  ||
                        (r_state == ST_DHI);
  assign in_ready     = r_live & w_readyState;
  assign w_inAccept   = in_valid & in_ready;
  assign busy         = (r_state != ST_IDLE);
  assign ren_ext      = 1'b0;

  // Header decode and address helpers shared by several states.
  assign w_hdrOp      = op_t'(in_data[HDR_OP_HI:HDR_OP_LO]);
  assign w_hdrCnt     = in_data[CNT_W-1:0];
  assign w_baseAddr   = {32'h0, in_data};
  assign w_nextAddr8  = r_addr + 64'd8;
  assign w_lastWord   = (r_cnt == CNT_ONE);

  // Main loader FSM. Every memory-side output is a register here; write and
  // read strobes default low each cycle so they behave as one-cycle pulses.
  // The data-memory read strobe is raised on the transition into ST_RD, so it
  // is visible during ST_RD and the read word arrives during ST_WAIT, where it
  // is captured into out_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_IMEM;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_lowBeat   <= '0;
      r_live      <= 1'b0;
      cpu_enable  <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      addr_ext    <= '0;
      wen_ext     <= 1'b0;
      wdata_ext   <= '0;
      addr_ext_2  <= '0;
      wen_ext_2   <= 1'b0;
      ren_ext_2   <= 1'b0;
      wdata_ext_2 <= '0;
    end else begin
      r_live    <= 1'b1;
      wen_ext   <= 1'b0;
      wen_ext_2 <= 1'b0;
      ren_ext_2 <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_inAccept) begin
            r_op  <= w_hdrOp;
            r_cnt <= w_hdrCnt;
            if (w_hdrOp == OP_ENABLE) begin
              cpu_enable <= in_data[HDR_EN_BIT];
            end else begin
              // Memory is only touched while the CPU is halted.
              cpu_enable <= 1'b0;
              r_state    <= ST_BASE;
            end
          end
        end

        ST_BASE: begin
          if (w_inAccept) begin
            r_addr <= w_baseAddr;
            if (r_cnt == '0) begin
              r_state <= ST_IDLE;
            end else begin
              case (r_op)
                OP_IMEM: r_state <= ST_IMEM;
                OP_DMEM: r_state <= ST_DLO;
                OP_DUMP: begin
                  r_state    <= ST_RD;
                  ren_ext_2  <= 1'b1;
                  addr_ext_2 <= w_baseAddr;
                end
                default: r_state <= ST_IDLE;
              endcase
            end
          end
        end

        ST_IMEM: begin
          if (w_inAccept) begin
            wen_ext   <= 1'b1;
            addr_ext  <= r_addr;
            wdata_ext <= in_data;
            r_addr    <= r_addr + 64'd4;
            r_cnt     <= r_cnt - CNT_ONE;
            if (w_lastWord) r_state <= ST_IDLE;
          end
        end

        ST_DLO: begin
          if (w_inAccept) begin
            r_lowBeat <= in_data;
            r_state   <= ST_DHI;
          end
        end

        ST_DHI: begin
          if (w_inAccept) begin
            wen_ext_2   <= 1'b1;
            addr_ext_2  <= r_addr;
            wdata_ext_2 <= {in_data, r_lowBeat};
            r_addr      <= w_nextAddr8;
            r_cnt       <= r_cnt - CNT_ONE;
            r_state     <= w_lastWord ? ST_IDLE : ST_DLO;
          end
        end

        ST_RD: begin
          r_state <= ST_WAIT;
        end

        ST_WAIT: begin
          out_data  <= rdata_ext_2;
          out_valid <= 1'b1;
          r_state   <= ST_OUT;
        end

        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_addr    <= w_nextAddr8;
            r_cnt     <= r_cnt - CNT_ONE;
            if (w_lastWord) begin
              r_state <= ST_IDLE;
            end else begin
              r_state    <= ST_RD;
              ren_ext_2  <= 1'b1;
              addr_ext_2 <= w_nextAddr8;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_cpu_mem_loader
// Scoreboard bench for cpu_mem_loader. The stimulus process pushes expected
// memory writes and dump words into queues; independent monitors pop and
// compare whenever the DUT presents a write pulse or a dump word. A small
// data-memory model answers the loader's reads one cycle after ren_ext_2.
// ---------------------------------------------------------------------------
module tb_cpu_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_ready;
  logic        cpu_enable;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [63:0] wdata_ext_2;
  logic [63:0] rdata_ext_2;
  logic        busy;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t         imemQ[$];
  wr_t         dmemQ[$];
  logic [63:0] dumpQ[$];
  logic [63:0] dmem[logic [63:0]];

  int checks     = 0;
  int failures   = 0;
  int imemWens   = 0;
  int dmemWens   = 0;
  int renPulses  = 0;

  cpu_mem_loader #(.CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .cpu_enable (cpu_enable),
    .addr_ext   (addr_ext),
    .wen_ext    (wen_ext),
    .ren_ext    (ren_ext),
    .wdata_ext  (wdata_ext),
    .addr_ext_2 (addr_ext_2),
    .wen_ext_2  (wen_ext_2),
    .ren_ext_2  (ren_ext_2),
    .wdata_ext_2(wdata_ext_2),
    .rdata_ext_2(rdata_ext_2),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Compare one value against its expectation and keep the tallies.
  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one stream word and hold it until the loader takes it.
  task automatic applyStimulus(input logic [31:0] word);
    int waitCycles = 0;
    in_valid = 1'b1;
    in_data  = word;
    while (!in_ready && waitCycles < 50) begin
      step();
      waitCycles++;
    end
    if (!in_ready) begin
      checkOutput("in_ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    step();
    in_valid = 1'b0;
  endtask

  // All control strobes, enable and addresses/data at their cleared values.
  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ctrl"},
                64'({in_ready, busy, cpu_enable, out_valid, wen_ext, ren_ext,
                     wen_ext_2, ren_ext_2}), 64'd0);
    checkOutput({tag, "_addr_ext"}, addr_ext, 64'd0);
    checkOutput({tag, "_addr_ext_2"}, addr_ext_2, 64'd0);
    checkOutput({tag, "_wdata_ext"}, 64'(wdata_ext), 64'd0);
    checkOutput({tag, "_wdata_ext_2"}, wdata_ext_2, 64'd0);
    checkOutput({tag, "_out_data"}, out_data, 64'd0);
  endtask

  // Data memory model: writes land immediately, reads return one cycle later.
  always @(posedge clk) begin
    if (wen_ext_2) dmem[addr_ext_2] = wdata_ext_2;
    if (ren_ext_2) rdata_ext_2 <= dmem.exists(addr_ext_2) ? dmem[addr_ext_2] : 64'h0;
  end

  // Instruction memory write monitor.
  always @(negedge clk) begin : monImem
    wr_t e;
    if (wen_ext) begin
      imemWens++;
      if (imemQ.size() == 0) begin
        checkOutput("imem_spurious_wen", 64'(wen_ext), 64'd0);
      end else begin
        e = imemQ.pop_front();
        checkOutput("imem_addr", addr_ext, e.addr);
        checkOutput("imem_data", 64'(wdata_ext), e.data);
      end
    end
  end

  // Data memory write monitor.
  always @(negedge clk) begin : monDmem
    wr_t e;
    if (wen_ext_2) begin
      dmemWens++;
      if (dmemQ.size() == 0) begin
        checkOutput("dmem_spurious_wen", 64'(wen_ext_2), 64'd0);
      end else begin
        e = dmemQ.pop_front();
        checkOutput("dmem_addr", addr_ext_2, e.addr);
        checkOutput("dmem_data", wdata_ext_2, e.data);
      end
    end
  end

  // Dump monitor: a stalled word must already hold the expected value;
  // the word is retired on the handshake.
  always @(negedge clk) begin : monDump
    if (ren_ext_2) renPulses++;
    if (out_valid) begin
      if (dumpQ.size() == 0) begin
        checkOutput("dump_spurious_valid", 64'(out_valid), 64'd0);
      end else if (out_ready) begin
        checkOutput("dump_data", out_data, dumpQ.pop_front());
      end else begin
        checkOutput("dump_hold", out_data, dumpQ[0]);
      end
    end
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed stimulus sequence.
  initial begin
    int budget;
    wr_t w;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    dmem[64'h18] = 64'h1122_3344_5566_7788;

    step();
    step();
    checkResetValues("reset");

    rst = 1'b0;
    checkOutput("in_ready_during_release", 64'(in_ready), 64'd0);
    step();
    checkOutput("in_ready_after_release", 64'(in_ready), 64'd1);

    $display("[TB] IMEM_WR three words");
    w.addr = 64'h0; w.data = 64'h0050_0093; imemQ.push_back(w);
    w.addr = 64'h4; w.data = 64'h00A0_0113; imemQ.push_back(w);
    w.addr = 64'h8; w.data = 64'h0020_81B3; imemQ.push_back(w);
    applyStimulus(32'h0000_0003);
    applyStimulus(32'h0000_0000);
    applyStimulus(32'h0050_0093);
    applyStimulus(32'h00A0_0113);
    applyStimulus(32'h0020_81B3);
    checkOutput("imem_busy_done", 64'(busy), 64'd0);
    step();
    step();
    checkOutput("imem_pulse_count", 64'(imemWens), 64'd3);

    $display("[TB] DMEM_WR one word");
    w.addr = 64'h10; w.data = 64'h0123_4567_DEAD_BEEF; dmemQ.push_back(w);
    applyStimulus(32'h4000_0001);
    applyStimulus(32'h0000_0010);
    applyStimulus(32'hDEAD_BEEF);
    applyStimulus(32'h0123_4567);
    step();
    step();
    checkOutput("dmem_pulse_count", 64'(dmemWens), 64'd1);
    checkOutput("dmem_busy_done", 64'(busy), 64'd0);

    $display("[TB] DMEM_DUMP two words with stalled host");
    dumpQ.push_back(64'h0123_4567_DEAD_BEEF);
    dumpQ.push_back(64'h1122_3344_5566_7788);
    applyStimulus(32'hC000_0002);
    applyStimulus(32'h0000_0010);
    checkOutput("dump_in_ready_low", 64'(in_ready), 64'd0);
    budget = 0;
    while (!out_valid && budget < 50) begin step(); budget++; end
    checkOutput("dump_first_valid", 64'(out_valid), 64'd1);
    repeat (5) step();
    out_ready = 1'b1;
    budget = 0;
    while (dumpQ.size() != 0 && budget < 50) begin step(); budget++; end
    checkOutput("dump_queue_drained", 64'(dumpQ.size()), 64'd0);
    step();
    step();
    out_ready = 1'b0;
    checkOutput("dump_ren_count", 64'(renPulses), 64'd2);
    checkOutput("dump_busy_done", 64'(busy), 64'd0);

    $display("[TB] ENABLE then IMEM_WR with N=0");
    applyStimulus(32'h8000_0001);
    checkOutput("enable_set", 64'(cpu_enable), 64'd1);
    applyStimulus(32'h0000_0000);
    checkOutput("enable_cleared_by_header", 64'(cpu_enable), 64'd0);
    checkOutput("n0_busy_in_base", 64'(busy), 64'd1);
    applyStimulus(32'h0000_0000);
    checkOutput("n0_idle_after_base", 64'(busy), 64'd0);
    step();
    step();
    checkOutput("n0_no_write", 64'(imemWens), 64'd3);

    $display("[TB] reset while waiting for the high beat");
    applyStimulus(32'h4000_0001);
    applyStimulus(32'h0000_0020);
    applyStimulus(32'hAAAA_5555);
    checkOutput("dhi_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    step();
    checkResetValues("midreset");
    rst = 1'b0;
    step();
    step();
    checkOutput("midreset_no_dmem_write", 64'(dmemWens), 64'd1);
    w.addr = 64'h100; w.data = 64'h1234_5678; imemQ.push_back(w);
    applyStimulus(32'h0000_0001);
    applyStimulus(32'h0000_0100);
    applyStimulus(32'h1234_5678);
    step();
    step();
    checkOutput("after_reset_imem_count", 64'(imemWens), 64'd4);

    $display("[TB] reserved bits, 64-bit address carry, stalled input");
    w.addr = 64'h0000_0000_FFFF_FFFC; w.data = 64'hCAFE_F00D; imemQ.push_back(w);
    w.addr = 64'h0000_0001_0000_0000; w.data = 64'h0BAD_C0DE; imemQ.push_back(w);
    applyStimulus(32'h3FFF_0002);
    applyStimulus(32'hFFFF_FFFC);
    applyStimulus(32'hCAFE_F00D);
    repeat (3) step();
    checkOutput("stall_busy", 64'(busy), 64'd1);
    applyStimulus(32'h0BAD_C0DE);
    step();
    step();
    checkOutput("final_imem_count", 64'(imemWens), 64'd6);
    checkOutput("final_imemQ_empty", 64'(imemQ.size()), 64'd0);
    checkOutput("final_dmemQ_empty", 64'(dmemQ.size()), 64'd0);
    checkOutput("final_busy", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_mem_loader.md
# cpu_mem_loader

Host-side initiator for the CPU's external memory ports. It takes a 32-bit command/payload stream over a valid/ready handshake and performs three jobs:
- writes words into instruction memory (`addr_ext`/`wen_ext`/`wdata_ext`);
- writes and reads back 64-bit words in data memory (`*_ext_2`);
- drives the CPU `enable` line.

It sits between the testbench or host link and the `cpu` top. It is the writer/reader counterpart of the CPU's external memory interface.

## Interface
- `CNT_W`, 16: width of the payload word-count field in the header.
- `clk`  in  1  main clock.
- `rst`  in  1  reset. Synchronous, active-high.
- `in_valid`  in  1  command/payload word valid.
- `in_data`  in  32  command/payload word.
- `in_ready`  out  1  loader accepts `in_data` this cycle.
- `out_valid`  out  1  dump word valid.
- `out_data`  out  64  dump word (data memory contents).
- `out_ready`  in  1  host accepts `out_data`.
- `cpu_enable`  out  1  drives cpu `enable`.
- `addr_ext`  out  64  instruction memory byte address.
- `wen_ext`  out  1  instruction memory write enable.
- `ren_ext`  out  1  instruction memory read enable. Tied to 0.
- `wdata_ext`  out  32  instruction memory write word.
- `addr_ext_2`  out  64  data memory byte address.
- `wen_ext_2`  out  1  data memory write enable.
- `ren_ext_2`  out  1  data memory read enable.
- `wdata_ext_2`  out  64  data memory write word.
- `rdata_ext_2`  in  64  data memory read word. Valid the cycle after `ren_ext_2`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
Header word format:
- `[31:30]` op: 00 = IMEM_WR, 01 = DMEM_WR, 10 = ENABLE, 11 = DMEM_DUMP.
- `[29:CNT_W]` reserved. Ignored.
- `[CNT_W-1:0]` N, the word count. For ENABLE, bit0 gives the new value of `cpu_enable`.

Command sequences:
- IMEM_WR, DMEM_WR and DMEM_DUMP are followed by one BASE word: byte address, zero-extended to 64 bits.
- IMEM_WR: N payload words follow. Word i is written to `addr_ext` = BASE + 4·i.
- DMEM_WR: N 64-bit words follow, each sent as two beats, low half first. Word i is written to `addr_ext_2` = BASE + 8·i.
- DMEM_DUMP: N words are read from BASE + 8·i and each is emitted on `out_*`.
- Any IMEM_WR, DMEM_WR or DMEM_DUMP header clears `cpu_enable` in the cycle the header is accepted. Memory is never touched while the CPU runs.

State machine (one-hot or encoded; implementer's choice):
- IDLE:
  - accept a header;
  - ENABLE → update `cpu_enable`, stay in IDLE;
  - all other ops → BASE.
- BASE:
  - accept the base word and load the address counter;
  - N = 0 → IDLE;
  - otherwise go by op: IMEM_WR → IMEM, DMEM_WR → DLO, DMEM_DUMP → RD.
- IMEM:
  - on each accepted word, pulse `wen_ext` for 1 cycle with address and data registered;
  - decrement the remaining count and advance the address by 4;
  - count reaches 0 → IDLE.
- DLO: accept the low beat into a holding register → DHI.
- DHI:
  - accept the high beat and pulse `wen_ext_2` with `{high, low}`;
  - advance the address by 8 and decrement the count;
  - count reaches 0 → IDLE, otherwise → DLO.
- RD: pulse `ren_ext_2` at the current address → WAIT.
- WAIT: capture `rdata_ext_2` into the `out_data` register and set `out_valid` → OUT.
- OUT:
  - hold `out_valid`/`out_data` stable until `out_ready`;
  - on the handshake, advance the address by 8 and decrement the count;
  - count reaches 0 → IDLE, otherwise → RD.

Rules:
- `in_ready` = 1 only in IDLE, BASE, IMEM, DLO and DHI. It is 0 in RD, WAIT and OUT.
- Address arithmetic is 64-bit modulo 2^64; wrap-around is silent.
- The count is CNT_W bits wide; N = 2^CNT_W − 1 is legal.
- No error reporting. The reserved header field is ignored.

## Timing
- Reset values (the cycle after `rst` is sampled high):
  - `cpu_enable`, `in_ready`, `out_valid`, `wen_ext`, `ren_ext`, `wen_ext_2`, `ren_ext_2`, `busy` = 0;
  - `addr_ext`, `addr_ext_2`, `wdata_ext`, `wdata_ext_2`, `out_data` = 0;
  - state = IDLE.
  - `in_ready` rises the cycle after `rst` falls.
- All memory-side outputs are registered. A write pulse appears the cycle after the accepting handshake.
- IMEM throughput: 1 word/cycle. DMEM write: 1 word per 2 accepted beats. Dump: at most 1 word per 3 cycles.
- Reset mid-command: the command is abandoned, the state returns to IDLE and `cpu_enable` = 0. Memory contents already written are kept.
- `in_valid` low mid-command stalls without timeout. `out_ready` low stalls OUT indefinitely.

## Structure
- Shared package `cpu_loader_pkg`:
  - op codes: `OP_IMEM`, `OP_DMEM`, `OP_ENABLE`, `OP_DUMP`;
  - state enum;
  - header field positions.
- Single module, no sub-modules. The FSM, counters and holding register live in one file.

## Test plan
- Reset then IMEM_WR: header 0x0000_0003, base 0x0, words 0x00500093, 0x00A00113, 0x002081B3 → three `wen_ext` pulses at addr 0, 4, 8 with those data. `busy` drops after the third.
- DMEM_WR: N = 1, base 0x10, beats 0xDEADBEEF, 0x01234567 → one `wen_ext_2` at addr 0x10 with data 0x01234567_DEADBEEF.
- DMEM_DUMP: N = 2, base 0x10 after the previous write, `out_ready` held low 5 cycles → `out_data` = 0x01234567_DEADBEEF held stable, then the word at 0x18. Only 2 `ren_ext_2` pulses.
- ENABLE header 0x8000_0001 → `cpu_enable` = 1. A following IMEM_WR header → `cpu_enable` = 0 in the cycle after acceptance.
- N = 0 for IMEM_WR (header 0x0000_0000 + base) → no write pulse, IDLE after 2 accepted words.
- `rst` asserted in DHI after the low beat → no `wen_ext_2`, all outputs at reset values, and the next header is accepted normally.
